// File: rtl/pe_seq_ctrl.sv
// Job sequencer for one PE: clear psum, stream len feature/weight reads, capture the ReLU result.
// Optional `define PE_SEQ_ABORT_EN adds an abort input that returns any active job to IDLE.
module pe_seq_ctrl #(
   parameter int unsigned LEN_W  = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
`ifdef PE_SEQ_ABORT_EN
   input  logic              abort,
`endif
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [ADDR_W-1:0] cfg_fbase,
   input  logic [ADDR_W-1:0] cfg_wbase,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] f_addr,
   output logic [ADDR_W-1:0] w_addr,
   output logic              pe_enable,
   output logic              pe_clear,
   input  logic [7:0]        pe_out,
   output logic [7:0]        result,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              done
);

   typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StCapt, StOut} state_e;

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] fbase_q, fbase_d;
   logic [ADDR_W-1:0] wbase_q, wbase_d;
   logic              busy_q, busy_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] f_addr_q, f_addr_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic              pe_enable_q, pe_enable_d;
   logic              pe_clear_q, pe_clear_d;
   logic [7:0]        result_q, result_d;
   logic              result_valid_q, result_valid_d;
   logic              done_q, done_d;

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      len_d          = len_q;
      fbase_d        = fbase_q;
      wbase_d        = wbase_q;
      rd_en_d        = 1'b0;
      f_addr_d       = f_addr_q;
      w_addr_d       = w_addr_q;
      // Enable trails the read strobe by one cycle to line up with buffer data.
      pe_enable_d    = rd_en_q;
      pe_clear_d     = 1'b0;
      result_d       = result_q;
      result_valid_d = 1'b0;
      done_d         = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               len_d      = cfg_len;
               fbase_d    = cfg_fbase;
               wbase_d    = cfg_wbase;
               idx_d      = '0;
               pe_clear_d = 1'b1;
               state_d    = StClear;
            end
         end
         StClear: begin
            if (len_q != '0) begin
               rd_en_d  = 1'b1;
               f_addr_d = fbase_q + ADDR_W'(idx_q);
               w_addr_d = wbase_q + ADDR_W'(idx_q);
               idx_d    = idx_q + LEN_W'(1);
               state_d  = StRun;
            end else begin
               state_d = StCapt;
            end
         end
         StRun: begin
            // idx_q counts reads already issued.
            if (idx_q == len_q) begin
               state_d = StDrain;
            end else begin
               rd_en_d  = 1'b1;
               f_addr_d = fbase_q + ADDR_W'(idx_q);
               w_addr_d = wbase_q + ADDR_W'(idx_q);
               idx_d    = idx_q + LEN_W'(1);
            end
         end
         StDrain: begin
            state_d = StCapt;
         end
         StCapt: begin
            result_d       = pe_out;
            result_valid_d = 1'b1;
            state_d        = StOut;
         end
         StOut: begin
            if (result_ready) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               result_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

`ifdef PE_SEQ_ABORT_EN
      if (abort && (state_q != StIdle)) begin
         state_d        = StIdle;
         rd_en_d        = 1'b0;
         pe_enable_d    = 1'b0;
         pe_clear_d     = 1'b0;
         result_valid_d = 1'b0;
         done_d         = 1'b0;
      end
`endif

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         idx_q          <= '0;
         len_q          <= '0;
         fbase_q        <= '0;
         wbase_q        <= '0;
         busy_q         <= 1'b0;
         rd_en_q        <= 1'b0;
         f_addr_q       <= '0;
         w_addr_q       <= '0;
         pe_enable_q    <= 1'b0;
         pe_clear_q     <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         len_q          <= len_d;
         fbase_q        <= fbase_d;
         wbase_q        <= wbase_d;
         busy_q         <= busy_d;
         rd_en_q        <= rd_en_d;
         f_addr_q       <= f_addr_d;
         w_addr_q       <= w_addr_d;
         pe_enable_q    <= pe_enable_d;
         pe_clear_q     <= pe_clear_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         done_q         <= done_d;
      end
   end

   assign busy         = busy_q;
   assign rd_en        = rd_en_q;
   assign f_addr       = f_addr_q;
   assign w_addr       = w_addr_q;
   assign pe_enable    = pe_enable_q;
   assign pe_clear     = pe_clear_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign done         = done_q;

endmodule

// File: doc/pe_seq_ctrl.md
# pe_seq_ctrl

Sequencer for one processing element (PE) and its partial-sum register. A job is a single dot product. For each job it:
- clears the partial sum,
- fetches `len` feature/weight pairs from two single-port buffers with 1-cycle read latency,
- pulses the PE accumulate enable once per pair,
- captures the ReLU'd 8-bit result and presents it on a valid/ready output.

It sits between the job-issuing host logic and the PE datapath.

## Interface
Parameters:
- `LEN_W`, default 8: width of the job length; maximum `len` is 2^LEN_W−1.
- `ADDR_W`, default 8: buffer address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `cfg_len`  in  LEN_W  number of pairs; latched when `start` is accepted.
- `cfg_fbase`  in  ADDR_W  feature buffer base address; latched when `start` is accepted.
- `cfg_wbase`  in  ADDR_W  weight buffer base address; latched when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `rd_en`  out  1  read strobe to both buffers.
- `f_addr`  out  ADDR_W  feature buffer read address.
- `w_addr`  out  ADDR_W  weight buffer read address.
- `pe_enable`  out  1  drives the PE `enable` input.
- `pe_clear`  out  1  drives the PE `reset` input, which zeroes the partial sum.
- `pe_out`  in  8  ReLU output of the PE, signed.
- `result`  out  8  captured result.
- `result_valid`  out  1  `result` is valid.
- `result_ready`  in  1  downstream accepts `result`.
- `done`  out  1  one-cycle pulse when the result is accepted.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, CAPT, OUT.
- IDLE: `start`=1 latches `cfg_*`, sets index `idx`=0, and moves to CLEAR. `start` is ignored in every other state.
- CLEAR: `pe_clear`=1 for one cycle.
  - Next state is RUN if `len`≠0.
  - Next state is CAPT if `len`=0; the result is then 0.
- RUN:
  - Drives `rd_en`=1, `f_addr`=`fbase`+`idx`, `w_addr`=`wbase`+`idx`.
  - Addresses are computed mod 2^ADDR_W; wrap-around is legal.
  - `idx` increments every cycle.
  - After the cycle with `idx`=`len`−1, next state is DRAIN.
- `pe_enable` is `rd_en` delayed by one register stage, so it lines up with the buffer read data. This gives exactly `len` enable cycles, the last one in DRAIN.
- DRAIN: `rd_en`=0; the last accumulate occurs. Next state is CAPT.
- CAPT: `result` <= `pe_out`, which equals ReLU(final psum) because enable=0 and reset=0. Next state is OUT.
- OUT:
  - `result_valid`=1.
  - `result` is held stable while `result_ready`=0.
  - On `result_valid`&`result_ready`: `done` pulses and the next state is IDLE.
- No back-to-back overlap: a new `start` is sampled only after the state has returned to IDLE.
- Reset values: state=IDLE; `idx`, `result`, and latched cfg = 0; `busy`, `rd_en`, `pe_enable`, `pe_clear`, `result_valid`, `done` = 0; `f_addr`, `w_addr` = 0.
- Reset asserted mid-job returns to IDLE at once. No `done` pulse is produced and no enable or clear is issued afterwards. The PE partial sum is stale until the next CLEAR.

## Timing
- Edge E samples `start`=1 in IDLE.
  - CLEAR occupies cycle E..E+1.
  - First `rd_en` occurs at E+1.
  - Last `pe_enable` occurs in cycle E+len+1..E+len+2.
  - `result_valid` rises at E+len+3.
- For `len`=0, `result_valid` rises at E+2.
- With `result_ready` held at 1, `done` is high for the cycle after the accepting edge and `busy` falls on that same edge. The minimum job-to-job period is `len`+5 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `PE_SEQ_ABORT_EN`
  - Defined: adds an input port `abort` (1 bit).
  - `abort`=1 in any non-IDLE state forces IDLE on the next edge.
  - An abort forces `rd_en`, `pe_enable`, `result_valid`, `done` to 0 in the following cycle and discards the result.
  - `abort` in IDLE has no effect. `abort` and `start` together in IDLE: `start` wins.
- Not defined: the `abort` port is absent and a job always runs to acceptance.

## Test plan
- f=[1,2,3], w=[4,5,6], `len`=3, `result_ready`=1 → `result`=32. `result_valid` rises 6 cycles after the `start` edge. Exactly 3 `pe_enable` cycles and 1 `pe_clear` cycle.
- f=[−3], w=[5] → psum −15 → `result`=0 (ReLU).
- f=[100,100], w=[2,2] → product saturates at 127, sum saturates at 127 → `result`=127.
- `len`=0 → `result`=0, `result_valid` at E+2, no `rd_en`.
- `fbase`=254, `len`=4 → `f_addr` sequence 254,255,0,1. Hold `result_ready`=0 for 5 cycles → `result` and `result_valid` are stable, `done` stays 0 until acceptance.
- Drop `reset_n` during RUN → all outputs 0 immediately. A `start` after reset release runs a clean job with correct results.
- With `PE_SEQ_ABORT_EN`: `abort` during RUN → IDLE next cycle, no `done` pulse, and a new job works.
